mdu_iter: RTL
=============

Name: mdu_iter

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the 32-bit MIPS datapath. It executes MULT/MULTU/DIV/DIVU in 32 iterations and MTHI/MTLO in one cycle. Its hi/lo outputs feed the 32-bit 2:1 result select in the execute stage, which chooses between ALU result and HI/LO. The busy output is used by hazard logic to stall on dependent MFHI/MFLO and further MDU ops.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  iteration in progress; new requests ignored
done  output  1  one-cycle pulse: HI/LO just updated by MUL/DIV
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, rst=1 at a clock edge: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. rst has priority over all inputs. Reset mid-operation aborts the op: no done pulse, and HI/LO read 0.
- States: IDLE, RUN.
- IDLE, start=1 with op in 000-011, at edge E0:
  - latch magnitudes of a/b (signed ops), or raw a/b (unsigned ops);
  - latch the sign-fix flags: quotient/product negate = a[31]^b[31]; remainder negate = a[31]; divide-by-zero flag = (b==0);
  - counter=0; busy=1; go to RUN.
- IDLE, start=1, op=100: hi<=a at E0. op=101: lo<=a at E0. busy and done stay 0.
- IDLE, start=1 with op 110/111, or start=0: no state change.
- RUN: one iteration per cycle.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - counter increments each cycle. The iteration with counter=31 occurs at edge E32.
- At E32:
  - hi/lo written with the final sign-corrected result;
  - busy<=0, done<=1, state<=IDLE.
  - done is 1 only for the cycle after E32 and clears at E33.
  - Result latency is 32 cycles after the start edge. A new request may be accepted at E33.
- start while busy=1 is ignored for every op, including MTHI/MTLO. HI/LO keep their old values during RUN.
- Multiply: {hi,lo} = full 64-bit product. For signed ops, the 64-bit magnitude product is two's-complement negated when the negate flag is set.
- Divide: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out naturally from the magnitude method.
- Divide by zero, signed or unsigned: lo=0xFFFFFFFF, hi=a (original dividend). Still takes 32 cycles with done pulse; no exception.
- hi/lo are registered outputs, not combinational from inputs.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF, start at E0 -> busy=1 for E0..E32; at E32 hi=FFFFFFFE, lo=00000001; done=1 for exactly one cycle.
- MULT a=FFFFFFFE, b=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA. MULT a=7FFFFFFF, b=7FFFFFFF -> hi=3FFFFFFF, lo=00000001.
- DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=00000007, b=00000002 -> lo=00000003, hi=00000001.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000. DIVU a=00001234, b=0 -> lo=FFFFFFFF, hi=00001234 after 32 cycles with done pulse.
- MTHI a=DEADBEEF while idle -> hi=DEADBEEF next cycle, lo unchanged, busy=0, done=0. Then during a MULTU, issue MTLO and MULT -> both ignored; the MULTU result is unaffected.
- rst=1 at the 10th RUN cycle of a DIVU -> next cycle busy=0, done=0, hi=lo=0, and no done pulse appears later. A following MULTU 3x5 completes normally: lo=0000000F, hi=0.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative 32-cycle MIPS multiply/divide unit with HI/LO registers
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    is_signed = ~op[0];
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: add multiplicand into upper half when the low bit is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Divide: shift partial remainder left by one dividend bit and trial-subtract.
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};

    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    quo  = acc_next[WIDTH-1:0];
    rem  = acc_next[2*WIDTH-1:WIDTH];
    prod = neg_q_q ? -acc_next : acc_next;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = op[1];
              opnd_d   = op[1] ? mag_b : mag_a;
              acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
              neg_q_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_d  = is_signed & a[WIDTH-1];
              dz_d     = (b == {WIDTH{1'b0}});
              cnt_d    = '0;
              state_d  = RUN;
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            // A zero divisor leaves the dividend as remainder; only the quotient is forced.
            lo_d = dz_q ? {WIDTH{1'b1}} : (neg_q_q ? -quo : quo);
            hi_d = neg_r_q ? -rem : rem;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
